// File: rtl/addsub_arbiter.sv
// Two-requester arbiter in front of one shared 4-bit add/subtract unit.
// Define ADDSUB_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (requester 0 wins).
module addsub_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       op0,
  input  logic       op1,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] b0,
  input  logic [3:0] b1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic [4:0] res,
  output logic       busy,
  output logic [7:0] ledr
);

  // state   | meaning
  // S_IDLE  | no operation in flight, waiting for any req
  // S_GRANT | winner granted, its operands are latched this cycle
  // S_EXEC  | shared adder runs on the latched operands, result registered
  // S_DONE  | done pulse to the winner, res valid, pick next winner
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_EXEC, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic [4:0] res_q, res_d;
  logic       cur_q, cur_d;
  logic       op_lat_q, op_lat_d;
  logic [3:0] a_lat_q, a_lat_d;
  logic [3:0] b_lat_q, b_lat_d;

  logic       win_idx;
  logic [3:0] b_eff;
  logic [4:0] carry;
  logic [3:0] sum;
  logic       ovf;

`ifdef ADDSUB_ARB_FIXED_PRIO_EN
  assign win_idx = ~req[0];
`else
  logic ptr_q, ptr_d;

  // The pointer moves in DONE; the winner chosen in DONE must already see the moved value.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_DONE) ptr_d = ~cur_q;
  end

  assign win_idx = (req == 2'b11) ? ptr_d : req[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`endif

  // Subtract as A + ~B + 1 through the carry-in, so the one adder also yields
  // the correct overflow when B = -8 (negation wraps).
  assign b_eff = b_lat_q ^ {4{op_lat_q}};

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = op_lat_q;
    for (int i = 0; i < 4; i++) begin
      sum[i]     = a_lat_q[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (a_lat_q[i] & b_eff[i]) | (a_lat_q[i] & carry[i]) | (b_eff[i] & carry[i]);
    end
  end

  assign ovf = carry[3] ^ carry[4];

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = 2'b00;
    res_d    = res_q;
    cur_d    = cur_q;
    op_lat_d = op_lat_q;
    a_lat_d  = a_lat_q;
    b_lat_d  = b_lat_q;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d = S_GRANT;
          cur_d   = win_idx;
          gnt_d   = win_idx ? 2'b10 : 2'b01;
        end
      end
      S_GRANT: begin
        op_lat_d = cur_q ? op1 : op0;
        a_lat_d  = cur_q ? a1  : a0;
        b_lat_d  = cur_q ? b1  : b0;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        res_d   = {ovf, sum};
        done_d  = cur_q ? 2'b10 : 2'b01;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (req != 2'b00) begin
          state_d = S_GRANT;
          cur_d   = win_idx;
          gnt_d   = win_idx ? 2'b10 : 2'b01;
        end else begin
          state_d = S_IDLE;
          gnt_d   = 2'b00;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      res_q    <= 5'd0;
      cur_q    <= 1'b0;
      op_lat_q <= 1'b0;
      a_lat_q  <= 4'd0;
      b_lat_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      res_q    <= res_d;
      cur_q    <= cur_d;
      op_lat_q <= op_lat_d;
      a_lat_q  <= a_lat_d;
      b_lat_q  <= b_lat_d;
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign res  = res_q;
  assign busy = (state_q != S_IDLE);
  assign ledr = {a_lat_q, b_lat_q};

endmodule
